// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Holds one hex value per digit, walks the digits in fixed-length slots and
// drives an active-low anode for each slot after a short all-off guard so the
// downstream registered cathode decoder has settled before a digit lights up.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] digit_en,
    output logic [3:0] encoded,
    output logic [7:0] anode,
    output logic [2:0] digit_sel,
    output logic       frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_SEL   = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       regs [0:7];
    logic             wrap;
    logic [2:0]       sel_next;

    // Anode pattern for a lit slot: only the selected digit may go low.
    function automatic logic [7:0] drive_pattern(input logic [2:0] sel,
                                                 input logic [7:0] en);
        logic [7:0] pat;
        pat      = 8'hFF;
        pat[sel] = ~en[sel];
        return pat;
    endfunction

    assign wrap     = (cnt == CNT_LAST);
    assign sel_next = (digit_sel == LAST_SEL) ? 3'd0 : digit_sel + 3'd1;

    // Digit register file; out-of-range addresses are dropped. Entries above
    // NUM_DIGITS-1 are never written nor read and exist only to keep the
    // 3-bit index width-exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 4'h0;
            end
        end else if (wr_en && (wr_addr <= LAST_SEL)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Slot counter, digit walk and BLANK/DRIVE sequencing with registered outputs.
    // The slot load reads regs before any same-edge write lands, so a write to
    // the digit being loaded shows up one frame later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            digit_sel  <= 3'd0;
            encoded    <= 4'h0;
            anode      <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            anode      <= 8'hFF;
            if (wrap) begin
                cnt        <= '0;
                state      <= BLANK;
                digit_sel  <= sel_next;
                encoded    <= regs[sel_next];
                frame_tick <= (sel_next == 3'd0);
            end else begin
                cnt <= cnt + CNT_W'(1);
                case (state)
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state <= DRIVE;
                            anode <= drive_pattern(digit_sel, digit_en);
                        end
                    end
                    DRIVE: begin
                        anode <= drive_pattern(digit_sel, digit_en);
                    end
                    default: begin
                        state <= BLANK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with 4 digits, 8-cycle slots and a 2-cycle guard.
// A cycle-indexed reference model derives every output from the elapsed cycle
// count since reset release; directed tables and sequences add hand values.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'h0;
    logic [7:0] digit_en = 8'hFF;
    logic [3:0] encoded;
    logic [7:0] anode;
    logic [2:0] digit_sel;
    logic       frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .digit_en  (digit_en),
        .encoded   (encoded),
        .anode     (anode),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: t counts cycles since reset release.
    int         t;
    logic [3:0] mregs [0:7];
    logic [3:0] enc_m;
    logic [7:0] anode_m;
    logic [2:0] sel_m;
    logic       tick_m;

    typedef struct {
        int         t;
        logic [7:0] anode;
        logic [2:0] sel;
        logic       tick;
    } v1_vec_t;

    typedef struct {
        int         pos;
        logic [3:0] enc;
    } v2_vec_t;

    v1_vec_t v1 [12];
    v2_vec_t v2 [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 8; i++) mregs[i] = 4'h0;
        enc_m   = 4'h0;
        anode_m = 8'hFF;
        sel_m   = 3'd0;
        tick_m  = 1'b0;
    endtask

    task automatic check_all();
        chk("anode", 32'(anode), 32'(anode_m));
        chk("encoded", 32'(encoded), 32'(enc_m));
        chk("digit_sel", 32'(digit_sel), 32'(sel_m));
        chk("frame_tick", 32'(frame_tick), 32'(tick_m));
        chk("anode_upper", 32'(anode[7:4]), 32'hF);
    endtask

    // One clock: advance the model from the inputs seen at this edge, then compare.
    task automatic tick();
        int cyc, slot, sel;
        @(posedge clk);
        t++;
        cyc  = t % RD;
        slot = t / RD;
        sel  = slot % ND;
        if (cyc == 0) enc_m = mregs[3'(sel)];
        if (wr_en && (int'(wr_addr) < ND)) mregs[wr_addr] = wr_data;
        anode_m = 8'hFF;
        if (cyc >= BC && digit_en[3'(sel)]) anode_m[3'(sel)] = 1'b0;
        sel_m  = 3'(sel);
        tick_m = (cyc == 0) && (sel == 0);
        #1;
        check_all();
    endtask

    task automatic run_until(input int target);
        while (t < target) tick();
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        v1[0]  = '{0,  8'hFF, 3'd0, 1'b0};
        v1[1]  = '{1,  8'hFF, 3'd0, 1'b0};
        v1[2]  = '{2,  8'hFE, 3'd0, 1'b0};
        v1[3]  = '{7,  8'hFE, 3'd0, 1'b0};
        v1[4]  = '{8,  8'hFF, 3'd1, 1'b0};
        v1[5]  = '{10, 8'hFD, 3'd1, 1'b0};
        v1[6]  = '{18, 8'hFB, 3'd2, 1'b0};
        v1[7]  = '{26, 8'hF7, 3'd3, 1'b0};
        v1[8]  = '{31, 8'hF7, 3'd3, 1'b0};
        v1[9]  = '{32, 8'hFF, 3'd0, 1'b1};
        v1[10] = '{33, 8'hFF, 3'd0, 1'b0};
        v1[11] = '{64, 8'hFF, 3'd0, 1'b1};

        v2[0] = '{0,  4'h1};
        v2[1] = '{7,  4'h1};
        v2[2] = '{8,  4'h2};
        v2[3] = '{15, 4'h2};
        v2[4] = '{16, 4'h3};
        v2[5] = '{23, 4'h3};
        v2[6] = '{24, 4'h4};
        v2[7] = '{31, 4'h4};

        // Reset held across clock edges.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();

        // V1: anode pattern and frame tick from reset release.
        for (int i = 0; i < 12; i++) begin
            run_until(v1[i].t);
            chk("v1_anode", 32'(anode), 32'(v1[i].anode));
            chk("v1_sel", 32'(digit_sel), 32'(v1[i].sel));
            chk("v1_tick", 32'(frame_tick), 32'(v1[i].tick));
        end

        // V2: load 1..4 and watch a full frame.
        for (int i = 0; i < 4; i++) write_reg(3'(i), 4'(i + 1));
        tick();
        while (t % FRAME != 0) tick();
        base = t;
        for (int i = 0; i < 8; i++) begin
            run_until(base + v2[i].pos);
            chk("v2_encoded", 32'(encoded), 32'(v2[i].enc));
        end

        // V3: write digit 2 while it is displayed.
        base = base + FRAME;
        run_until(base + 16 + 3);
        write_reg(3'd2, 4'hA);
        while (t < base + 24) begin
            chk("v3_hold", 32'(encoded), 32'h3);
            tick();
        end
        run_until(base + FRAME + 16);
        chk("v3_next_frame", 32'(encoded), 32'hA);

        // Write landing on the same edge as that digit's slot load.
        base = base + 2 * FRAME;
        run_until(base + 7);
        write_reg(3'd1, 4'hB);
        chk("same_edge_old", 32'(encoded), 32'h2);
        run_until(base + FRAME + 8);
        chk("same_edge_next", 32'(encoded), 32'hB);

        // V4: only digits 0 and 2 enabled.
        digit_en = 8'b0000_0101;
        base = base + 2 * FRAME;
        run_until(base);
        run_until(base + 2);
        chk("v4_slot0", 32'(anode), 32'hFE);
        run_until(base + 12);
        chk("v4_slot1", 32'(anode), 32'hFF);
        run_until(base + 18);
        chk("v4_slot2", 32'(anode), 32'hFB);
        run_until(base + 30);
        chk("v4_slot3", 32'(anode), 32'hFF);
        run_until(base + FRAME);
        chk("v4_tick", 32'(frame_tick), 32'h1);
        digit_en = 8'hFF;

        // V5: out-of-range writes are ignored.
        write_reg(3'd5, 4'hF);
        write_reg(3'd7, 4'h9);
        write_reg(3'd4, 4'hE);
        base = base + 2 * FRAME;
        run_until(base);
        chk("v5_reg0", 32'(encoded), 32'h1);
        run_until(base + 8);
        chk("v5_reg1", 32'(encoded), 32'hB);
        run_until(base + 24);
        chk("v5_reg3", 32'(encoded), 32'h4);

        // V6: asynchronous reset at slot 1 cycle 5.
        run_until(base + FRAME + 13);
        chk("v6_pre", 32'(anode), 32'hFD);
        #1;
        rst = 1'b1;
        #1;
        chk("v6_async_anode", 32'(anode), 32'hFF);
        chk("v6_async_sel", 32'(digit_sel), 32'h0);
        chk("v6_async_enc", 32'(encoded), 32'h0);
        chk("v6_async_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        run_until(1);
        chk("v6_blank", 32'(anode), 32'hFF);
        run_until(2);
        chk("v6_restart", 32'(anode), 32'hFE);
        run_until(8);
        chk("v6_sel1", 32'(digit_sel), 32'h1);
        chk("v6_cleared", 32'(encoded), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1200; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of scanned digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: slot length per digit, in clk cycles.
REQ-003 Parameter BLANK_CYCLES, default 16: anode-off guard at the start of each slot; 2 <= BLANK_CYCLES < REFRESH_DIV.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port wr_en, input, 1 bit: digit register write strobe.
REQ-007 Port wr_addr, input, 3 bits: digit index to write.
REQ-008 Port wr_data, input, 4 bits: hex value 0-F to store.
REQ-009 Port digit_en, input, 8 bits: per-digit enable; 0 keeps that digit dark.
REQ-010 Port encoded, output, 4 bits: hex value for the downstream cathode decoder, registered.
REQ-011 Port anode, output, 8 bits: active-low digit drive, registered.
REQ-012 Port digit_sel, output, 3 bits: index of the current slot, registered.
REQ-013 Port frame_tick, output, 1 bit: one-cycle pulse marking the start of each frame, registered.

Function
REQ-014 Register file: NUM_DIGITS x 4 bits. wr_en=1 with wr_addr < NUM_DIGITS writes wr_data on the clock edge; wr_addr >= NUM_DIGITS is ignored.
REQ-015 Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, digit_sel increments; NUM_DIGITS-1 wraps to 0.
REQ-016 Two-state FSM:
- BLANK for slot cycles 0..BLANK_CYCLES-1.
- DRIVE for slot cycles BLANK_CYCLES..REFRESH_DIV-1.
- DRIVE goes to BLANK on counter wrap.
REQ-017 On the edge that begins a slot, encoded loads regfile[new digit_sel]. encoded holds that value for the whole slot.
REQ-018 In BLANK, anode = 8'hFF. The guard covers the decoder's 1-cycle registered latency and prevents ghosting.
REQ-019 In DRIVE, anode[digit_sel] = ~digit_en[digit_sel]. All other anode bits are 1.
REQ-020 anode bits at index >= NUM_DIGITS are always 1.
REQ-021 A write to the digit currently displayed does not change encoded mid-slot. The new value appears at that digit's next slot.
REQ-022 A write landing on the same edge as that digit's slot load: the load takes the pre-write value. The new value shows on the next frame.
REQ-023 frame_tick = 1 for exactly the first cycle of each slot 0, except the first slot after reset release.
REQ-024 digit_en changes take effect on the next cycle's anode. No slot restart occurs.
REQ-025 NUM_DIGITS = 1: digit_sel stays 0. BLANK/DRIVE still alternate every slot, and frame_tick pulses every slot.
REQ-026 Slot timing is independent of register writes and enables. Every digit gets exactly REFRESH_DIV cycles per frame.

Reset
REQ-027 While rst = 1, the block holds:
- anode = 8'hFF; encoded = 4'h0; digit_sel = 0; frame_tick = 0.
- Counter = 0; FSM = BLANK; all register-file entries = 4'h0.
REQ-028 rst asserted mid-slot forces the reset state immediately, without waiting for a clock edge.
REQ-029 After rst deasserts, the first rising edge is slot-0 cycle 1. Scanning proceeds normally from there.

Verification
REQ-030 A bench covers these directed scenarios, with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2:
- V1 Reset release with all digits enabled: anode = F for 2 cycles, then E for 6 cycles, D, B, 7 patterns follow in later slots. frame_tick pulses at cycle 32 and every 32 cycles after.
- V2 Write regs 0..3 = 1,2,3,4: encoded sequence over a frame is 1,2,3,4. Each value changes only on a slot boundary.
- V3 Write reg 2 = A during slot 2: encoded stays at the old value for the rest of slot 2. A appears in slot 2 of the next frame.
- V4 digit_en = 8'b0000_0101: anode low only in slots 0 and 2. Slots 1 and 3 stay F; slot length is unchanged.
- V5 wr_addr = 5 with wr_en: no register changes. Upper anode bits stay 1 throughout.
- V6 rst asserted at slot 1 cycle 5: anode = FF within the same cycle with no clock edge. After release, scanning restarts at digit 0 with the counter at 0.
